// File: rtl/param_burst_memory.sv
// -----------------------------------------------------------------------------
// param_burst_memory
//   Synthesizable main-memory model with DRAM-like open-row timing. A request is
//   accepted in IDLE, waits ACCESS_CYCLES (row miss) or PAGE_CYCLES (row hit)
//   and is then served as BURST_LEN consecutive 64-bit beats, followed by one
//   DONE cycle that lets the requester drop its request.
//
// Ports
//   clk_i          clock, all logic on posedge
//   rst_i          synchronous active-high reset (aborts any access)
//   mem_read_i     read request, held high until the burst completes
//   mem_write_i    write request, held high until the burst completes
//   mem_address_i  byte address of the line; the in-line offset bits are ignored
//   mem_wdata_i    write beat, sampled on every cycle mem_resp_o=1 of a write
//   mem_rdata_o    read beat, valid when mem_resp_o=1 of a read; holds otherwise
//   mem_resp_o     beat strobe, high BURST_LEN consecutive cycles per access
// -----------------------------------------------------------------------------
module param_burst_memory #(
  parameter int ACCESS_CYCLES = 50,
  parameter int PAGE_CYCLES   = 25,
  parameter int BURST_LEN     = 4,
  parameter int ROW_BYTES     = 256,
  parameter int NUM_ROWS      = 512
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] mem_address_i,
  input  logic [63:0] mem_wdata_i,
  output logic [63:0] mem_rdata_o,
  output logic        mem_resp_o
);

  localparam int NUM_WORDS = (ROW_BYTES * NUM_ROWS) / 8;
  localparam int AW        = $clog2(NUM_WORDS);       // 64-bit word index width
  localparam int BW        = $clog2(BURST_LEN);       // beat index width
  localparam int LW        = AW - BW;                 // line index width
  localparam int RB        = $clog2(ROW_BYTES);
  localparam int RW        = $clog2(NUM_ROWS);
  localparam int MAX_LAT   = (ACCESS_CYCLES > PAGE_CYCLES) ? ACCESS_CYCLES : PAGE_CYCLES;
  localparam int CW        = $clog2(MAX_LAT + 1);

  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [CW-1:0] MISS_M1   = CW'(ACCESS_CYCLES - 1);
  localparam logic [CW-1:0] HIT_M1    = CW'(PAGE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e        state_q;
  logic          is_write_q;
  logic [LW-1:0] line_q;
  logic [RW-1:0] row_q;
  logic          row_valid_q;
  logic [CW-1:0] count_q;
  logic [BW-1:0] beat_q;
  logic          resp_q;
  logic [63:0]   rdata_q;

  logic [63:0]   mem_q [NUM_WORDS];

  logic          req_s;
  logic [RW-1:0] addr_row_s;
  logic [CW-1:0] lat_m1_s;
  logic [BW-1:0] rd_beat_s;
  logic [AW-1:0] rd_idx_s;
  logic [AW-1:0] wr_idx_s;
  logic          wr_en_s;
  logic          unused_s;

  assign req_s      = mem_read_i | mem_write_i;
  // Taking the row from the low address bits makes addresses beyond capacity alias.
  assign addr_row_s = mem_address_i[RB+RW-1:RB];
  assign lat_m1_s   = (row_valid_q && (row_q == addr_row_s)) ? HIT_M1 : MISS_M1;
  assign rd_idx_s   = {line_q, rd_beat_s};
  assign wr_idx_s   = {line_q, beat_q};
  // A beat is only committed while the requester still holds its request.
  assign wr_en_s    = (state_q == BURST) && is_write_q && req_s;
  assign unused_s   = ^{mem_address_i[31:AW+3], mem_address_i[BW+2:0]};

  // Word to prefetch into the read register: beat 0 on WAIT exit, next beat in BURST.
  always_comb begin
    rd_beat_s = '0;
    if (state_q == BURST) begin
      rd_beat_s = beat_q + BW'(1);
    end else begin
      rd_beat_s = '0;
    end
  end

  // Storage array, deliberately without reset so it maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_q[wr_idx_s] <= mem_wdata_i;
    end
  end

  // Access FSM with open-row tracking and registered response outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      is_write_q  <= 1'b0;
      line_q      <= '0;
      row_q       <= '0;
      row_valid_q <= 1'b0;
      count_q     <= '0;
      beat_q      <= '0;
      resp_q      <= 1'b0;
      rdata_q     <= 64'd0;
    end else begin
      case (state_q)
        IDLE: begin
          resp_q <= 1'b0;
          if (req_s) begin
            // Read wins when both request lines are high.
            is_write_q  <= mem_write_i & ~mem_read_i;
            line_q      <= mem_address_i[AW+2:BW+3];
            row_q       <= addr_row_s;
            row_valid_q <= 1'b1;
            count_q     <= lat_m1_s;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (!req_s) begin
            state_q <= IDLE;
            resp_q  <= 1'b0;
          end else if (count_q == '0) begin
            state_q <= BURST;
            beat_q  <= '0;
            resp_q  <= 1'b1;
            if (!is_write_q) begin
              rdata_q <= mem_q[rd_idx_s];
            end
          end else begin
            count_q <= count_q - CW'(1);
          end
        end
        BURST: begin
          if (!req_s) begin
            state_q <= IDLE;
            resp_q  <= 1'b0;
          end else if (beat_q == LAST_BEAT) begin
            state_q <= DONE;
            resp_q  <= 1'b0;
          end else begin
            beat_q <= beat_q + BW'(1);
            if (!is_write_q) begin
              rdata_q <= mem_q[rd_idx_s];
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          resp_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          resp_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_resp_o  = resp_q;
  assign mem_rdata_o = rdata_q;

endmodule

// File: tb/tb_param_burst_memory.sv
// -----------------------------------------------------------------------------
// tb_param_burst_memory
//   Directed bench for param_burst_memory (ACCESS_CYCLES=6, PAGE_CYCLES=3).
//   The stimulus process issues accesses and pushes the expected beat cycle and
//   data into a scoreboard queue; an independent monitor pops and compares on
//   every cycle the DUT raises mem_resp_o.
// -----------------------------------------------------------------------------
module tb_param_burst_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata_o;
  logic        mem_resp_o;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int          cyc;
    logic [63:0] data;
    bit          chk;
  } exp_t;

  exp_t sb_q[$];

  param_burst_memory #(
    .ACCESS_CYCLES(6),
    .PAGE_CYCLES  (3),
    .BURST_LEN    (4),
    .ROW_BYTES    (256),
    .NUM_ROWS     (512)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .mem_read_i   (mem_read),
    .mem_write_i  (mem_write),
    .mem_address_i(mem_address),
    .mem_wdata_i  (mem_wdata),
    .mem_rdata_o  (mem_rdata_o),
    .mem_resp_o   (mem_resp_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h expected 0x%h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] beat_pat(input logic [7:0] base, input int i);
    logic [7:0] b;
    b = base + 8'(8'h11 * i);
    return {8{b}};
  endfunction

  // One full access: request, expected beats to the scoreboard, wdata per beat,
  // then check the single DONE cycle and drop the request.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input int lat, input logic [7:0] wbase, input logic [7:0] ebase,
                        input bit chk_data);
    int   acc;
    int   n;
    int   guard;
    exp_t e;
    @(negedge clk);
    mem_read    = rd;
    mem_write   = wr;
    mem_address = addr;
    acc = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      e.cyc  = acc + lat + i;
      e.data = beat_pat(ebase, i);
      e.chk  = chk_data;
      sb_q.push_back(e);
    end
    n = 0;
    guard = 0;
    while (n < 4 && guard < 40) begin
      @(negedge clk);
      guard++;
      if (mem_resp_o) begin
        mem_wdata = beat_pat(wbase, n);
        n++;
      end
    end
    if (n < 4) begin
      total++;
      bad++;
      $display("FAIL burst_timeout: got %0d beats expected 4", n);
      sb_q.delete();
    end
    @(negedge clk);
    check("done_cycle_resp", 64'(mem_resp_o), 64'd0);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // Monitor: every asserted beat must match the head of the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && mem_resp_o) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got resp=1 expected 0 (cyc %0d)", cyc);
        end else begin
          e = sb_q.pop_front();
          check("beat_cycle", 64'(cyc), 64'(e.cyc));
          if (e.chk) check("rdata", mem_rdata_o, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst         = 1'b1;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = 32'd0;
    mem_wdata   = 64'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_resp", 64'(mem_resp_o), 64'd0);
    check("reset_rdata", mem_rdata_o, 64'd0);

    // 1: write line 0x40, row miss
    access(1'b0, 1'b1, 32'h0000_0040, 6, 8'h11, 8'h00, 1'b0);
    // 2: read back, row hit
    access(1'b1, 1'b0, 32'h0000_0040, 3, 8'h00, 8'h11, 1'b1);
    // 3: second row; low bits of 0x150 are ignored
    access(1'b0, 1'b1, 32'h0000_0140, 6, 8'h55, 8'h00, 1'b0);
    access(1'b1, 1'b0, 32'h0000_0040, 6, 8'h00, 8'h11, 1'b1);
    access(1'b1, 1'b0, 32'h0000_0140, 6, 8'h00, 8'h55, 1'b1);
    access(1'b1, 1'b0, 32'h0000_0150, 3, 8'h00, 8'h55, 1'b1);

    // 4: reset in the second WAIT cycle aborts and closes the open row
    @(negedge clk);
    mem_read    = 1'b1;
    mem_address = 32'h0000_0040;
    repeat (2) @(negedge clk);
    rst      = 1'b1;
    mem_read = 1'b0;
    @(negedge clk);
    check("rst_abort_resp", 64'(mem_resp_o), 64'd0);
    check("rst_abort_rdata", mem_rdata_o, 64'd0);
    rst = 1'b0;
    access(1'b1, 1'b0, 32'h0000_0140, 6, 8'h00, 8'h55, 1'b1);

    // 5: read and write together behave as a read; array untouched
    access(1'b1, 1'b1, 32'h0000_0040, 6, 8'h99, 8'h11, 1'b1);
    access(1'b1, 1'b0, 32'h0000_0040, 3, 8'h00, 8'h11, 1'b1);

    // 6: address beyond capacity aliases onto 0x40 (same row 0, so a hit)
    access(1'b0, 1'b1, 32'h0002_0040, 3, 8'hA1, 8'h00, 1'b0);
    access(1'b1, 1'b0, 32'h0000_0040, 3, 8'h00, 8'hA1, 1'b1);

    // 7: dropping the request during WAIT aborts without any beat
    @(negedge clk);
    mem_read    = 1'b1;
    mem_address = 32'h0000_0040;
    repeat (2) @(negedge clk);
    mem_read = 1'b0;
    repeat (12) @(negedge clk);
    check("wait_abort_resp", 64'(mem_resp_o), 64'd0);
    access(1'b1, 1'b0, 32'h0000_0040, 3, 8'h00, 8'hA1, 1'b1);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
